vga_sync_gen: RTL

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_timing_pkg.sv | 47 ++++
 rtl/vga_axis_counter.sv | 76 +++++++
 rtl/vga_sync_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: the phase enum, default 640x480@60 timing
// and the helpers that derive and validate per-axis totals.
package vga_timing_pkg;

  // Position counters are 10 bits wide, so neither axis may exceed 1024.
  localparam int unsigned CNT_W     = 10;
  localparam int unsigned MAX_TOTAL = 1 << CNT_W;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;

  // One axis walks through these phases in order and then wraps.
  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
    return active + front + sync + back;
  endfunction

  // Legal when every phase has at least one unit and the total fits CNT_W.
  function automatic bit axis_legal(input int unsigned active,
                                    input int unsigned front,
                                    input int unsigned sync,
                                    input int unsigned back);
    return (active != 0) && (front != 0) && (sync != 0) && (back != 0) &&
           (axis_total(active, front, sync, back) <= MAX_TOTAL);
  endfunction

  localparam int unsigned DEF_H_TOTAL =
    axis_total(DEF_H_ACTIVE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int unsigned DEF_V_TOTAL =
    axis_total(DEF_V_ACTIVE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a position counter wrapping at TOTAL-1, a phase machine
// ACTIVE -> FRONT -> SYNC -> BACK that always describes the current count,
// and a wrap strobe for cascading into the next axis.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FRONT  = DEF_H_FRONT,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BACK   = DEF_H_BACK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_step,
  output logic [CNT_W-1:0] o_count,
  output phase_e           o_phase,
  output logic             o_wrap
);

  localparam int unsigned TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);

  if (!axis_legal(ACTIVE, FRONT, SYNC, BACK)) begin : g_bad_timing
    $error("vga_axis_counter: zero-length phase or total above %0d", MAX_TOTAL);
  end

  // Last count of each phase; the machine advances when its phase ends.
  localparam logic [CNT_W-1:0] LAST_ACTIVE = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] LAST_FRONT  = CNT_W'(ACTIVE + FRONT - 1);
  localparam logic [CNT_W-1:0] LAST_SYNC   = CNT_W'(ACTIVE + FRONT + SYNC - 1);
  localparam logic [CNT_W-1:0] LAST_COUNT  = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] count_q, count_d;
  phase_e           phase_q, phase_d;
  logic             at_last;

  assign at_last = (count_q == LAST_COUNT);

  // Next count and phase: clear wins, otherwise advance on step.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    count_d = count_q;
    phase_d = phase_q;
    if (i_clear) begin
      count_d = '0;
      phase_d = PH_ACTIVE;
    end else if (i_step) begin
      count_d = at_last ? '0 : count_q + 1'b1;
      unique case (phase_q)
        PH_ACTIVE: if (count_q == LAST_ACTIVE) phase_d = PH_FRONT;
        PH_FRONT:  if (count_q == LAST_FRONT)  phase_d = PH_SYNC;
        PH_SYNC:   if (count_q == LAST_SYNC)   phase_d = PH_BACK;
        PH_BACK:   if (at_last)                phase_d = PH_ACTIVE;
      endcase
    end
  end

  // Count and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      count_q <= '0;
      phase_q <= PH_ACTIVE;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign o_count = count_q;
  assign o_phase = phase_q;
  assign o_wrap  = i_step && !i_clear && at_last;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: a horizontal axis counter cascaded into a vertical one,
// decoded into sync, active and tick strobes. All outputs are registered and
// describe the internal position held before the edge (one cycle latency).
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT         = DEF_H_FRONT,
  parameter int unsigned H_SYNC          = DEF_H_SYNC,
  parameter int unsigned H_BACK          = DEF_H_BACK,
  parameter int unsigned V_ACTIVE        = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT         = DEF_V_FRONT,
  parameter int unsigned V_SYNC          = DEF_V_SYNC,
  parameter int unsigned V_BACK          = DEF_V_BACK,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Enable,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic             o_Active,
  output logic [CNT_W-1:0] o_Col,
  output logic [CNT_W-1:0] o_Row,
  output logic             o_LineTick,
  output logic             o_NewFrameTick
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  if (!axis_legal(H_ACTIVE, H_FRONT, H_SYNC, H_BACK) ||
      !axis_legal(V_ACTIVE, V_FRONT, V_SYNC, V_BACK)) begin : g_bad_timing
    $error("vga_sync_gen: illegal timing (H_TOTAL=%0d V_TOTAL=%0d)", H_TOTAL, V_TOTAL);
  end

  localparam logic             SYNC_ON   = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic             SYNC_OFF  = ~SYNC_ON;
  localparam logic [CNT_W-1:0] FRAME_ROW = CNT_W'(V_ACTIVE);

  logic [CNT_W-1:0] h_count, v_count;
  phase_e           h_phase, v_phase;
  logic             h_wrap, v_wrap_unused;
  logic             run_clear;

  // Dropping enable parks both axes at (0,0)/ACTIVE on the next edge.
  assign run_clear = !i_Enable;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) u_h_axis (
    .clk     (i_Clk),
    .rst_n   (i_Rst_L),
    .i_clear (run_clear),
    .i_step  (i_Enable),
    .o_count (h_count),
    .o_phase (h_phase),
    .o_wrap  (h_wrap)
  );

  // The row advances only on the column wrap.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) u_v_axis (
    .clk     (i_Clk),
    .rst_n   (i_Rst_L),
    .i_clear (run_clear),
    .i_step  (i_Enable && h_wrap),
    .o_count (v_count),
    .o_phase (v_phase),
    .o_wrap  (v_wrap_unused)
  );

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             active_q, active_d;
  logic             line_tick_q, line_tick_d;
  logic             frame_tick_q, frame_tick_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;

  // Decode the current position; idle values whenever the generator is held.
  always_comb begin
    hsync_d      = SYNC_OFF;
    vsync_d      = SYNC_OFF;
    active_d     = 1'b0;
    line_tick_d  = 1'b0;
    frame_tick_d = 1'b0;
    col_d        = '0;
    row_d        = '0;
    if (i_Enable) begin
      hsync_d      = (h_phase == PH_SYNC) ? SYNC_ON : SYNC_OFF;
      vsync_d      = (v_phase == PH_SYNC) ? SYNC_ON : SYNC_OFF;
      active_d     = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
      line_tick_d  = (h_count == '0);
      frame_tick_d = (h_count == '0) && (v_count == FRAME_ROW);
      col_d        = h_count;
      row_d        = v_count;
    end
  end

  // Output registers, all aligned to the same pixel.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hsync_q      <= SYNC_OFF;
      vsync_q      <= SYNC_OFF;
      active_q     <= 1'b0;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
    end else begin
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      active_q     <= active_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
      col_q        <= col_d;
      row_q        <= row_d;
    end
  end

  assign o_HSync        = hsync_q;
  assign o_VSync        = vsync_q;
  assign o_Active       = active_q;
  assign o_LineTick     = line_tick_q;
  assign o_NewFrameTick = frame_tick_q;
  assign o_Col          = col_q;
  assign o_Row          = row_q;

endmodule
